// File: rtl/max31855_pkg.sv
// Shared constants, frame field layout and FSM state type for the MAX31855 responder.
package max31855_pkg;

  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = 6;

  localparam int TC_MSB    = 31;
  localparam int TC_LSB    = 18;
  localparam int FAULT_BIT = 16;
  localparam int INT_MSB   = 15;
  localparam int INT_LSB   = 4;
  localparam int SCV_BIT   = 2;
  localparam int SCG_BIT   = 1;
  localparam int OC_BIT    = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_OVERRUN
  } state_t;

  // Unused bits (17 and 3) stay zero as on the real device.
  function automatic logic [FRAME_BITS-1:0] pack_word(
    input logic [13:0] tc_temp,
    input logic [11:0] int_temp,
    input logic        scv,
    input logic        scg,
    input logic        oc
  );
    logic [FRAME_BITS-1:0] w;
    w                  = '0;
    w[TC_MSB:TC_LSB]   = tc_temp;
    w[FAULT_BIT]       = scv | scg | oc;
    w[INT_MSB:INT_LSB] = int_temp;
    w[SCV_BIT]         = scv;
    w[SCG_BIT]         = scg;
    w[OC_BIT]          = oc;
    return w;
  endfunction

endpackage

// File: rtl/max31855_responder_if.sv
// SPI pins between a bus master and the MAX31855 responder.
interface max31855_responder_if;
  logic spi_sck_i;
  logic spi_cs_i;
  logic spi_miso_o;
  logic spi_miso_oe_o;

  modport master (output spi_sck_i, spi_cs_i, input spi_miso_o, spi_miso_oe_o);
  modport slave  (input spi_sck_i, spi_cs_i, output spi_miso_o, spi_miso_oe_o);
endinterface

// File: rtl/max31855_responder_sync_edge_det.sv
// Multi-flop synchronizer with registered rise/fall detection for one asynchronous input.
module sync_edge_det #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   flush_q;
  logic              prev_q;
  logic              armed_q;
  logic              level;

  assign level = sync_q[STAGES-1];

  // Edges are only reported once the chain has flushed its reset value and then
  // seen the real input at its idle level, so a line already active at reset
  // release cannot fake an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {STAGES{IDLE_LVL}};
      flush_q <= '0;
      prev_q  <= IDLE_LVL;
      armed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns this chain into a real shift register.
      sync_q  <= {sync_q[STAGES-2:0], async_i};
      flush_q <= {flush_q[STAGES-1:0], 1'b1};
      prev_q  <= level;
      if (flush_q[STAGES] && (level == IDLE_LVL))
        armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q &  level & ~prev_q;
  assign fall_o = armed_q & ~level &  prev_q;

endmodule

// File: rtl/max31855_responder.sv
// MAX31855 thermocouple converter emulator: serves a 32-bit shadow word over SPI mode 0.
module max31855_responder
  import max31855_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  max31855_responder_if.slave  spi,
  input  logic [13:0]          tc_temp_i,
  input  logic [11:0]          int_temp_i,
  input  logic                 fault_scv_i,
  input  logic                 fault_scg_i,
  input  logic                 fault_oc_i,
  input  logic                 update_i,
  output logic                 frame_done_o,
  output logic                 frame_abort_o
);

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sck_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (spi.spi_sck_i),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_cs_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (spi.spi_cs_i),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  logic [FRAME_BITS-1:0] shadow_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  miso_q;
  logic                  miso_oe_q;
  state_t                state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      shadow_q <= '0;
    else if (update_i)
      shadow_q <= pack_word(tc_temp_i, int_temp_i, fault_scv_i, fault_scg_i, fault_oc_i);
  end

  // CS rise is handled ahead of the state case so it always beats a
  // simultaneous SCK edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_abort_o <= 1'b0;
    end else begin
      frame_done_o  <= 1'b0;
      frame_abort_o <= 1'b0;
      if (state_q != ST_IDLE && cs_rise) begin
        state_q   <= ST_IDLE;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        if (bit_cnt_q >= CNT_W'(FRAME_BITS))
          frame_done_o  <= 1'b1;
        else
          frame_abort_o <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall) begin
              shift_q   <= shadow_q;
              bit_cnt_q <= '0;
              miso_q    <= shadow_q[FRAME_BITS-1];
              miso_oe_q <= 1'b1;
              state_q   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CNT_W'(FRAME_BITS - 1))
                state_q <= ST_OVERRUN;
            end else if (sck_fall) begin
              shift_q <= shift_q << 1;
              miso_q  <= shift_q[FRAME_BITS-2];
            end
          end
          ST_OVERRUN: begin
            // bit_cnt holds at FRAME_BITS so the end-of-frame test cannot wrap.
            miso_q <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi.spi_miso_o    = miso_q;
  assign spi.spi_miso_oe_o = miso_oe_q;

endmodule
